// File: rtl/out_requant_pipe_pkg.sv
// Shared definitions for the output requantisation pipeline.
// Holds parameter defaults, lane packing helper and signed saturation bounds.
package out_requant_pipe_pkg;

  localparam int unsigned LANES_DEF = 4;
  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned Q_W_DEF   = 8;
  localparam int unsigned SHW_DEF   = 5;
  localparam int unsigned CNT_W_DEF = 16;

  // LSB position of a lane inside a packed bus; lane 0 occupies the MSBs.
  function automatic int unsigned lane_lsb(input int unsigned lanes, input int unsigned w,
                                           input int unsigned lane);
    return (lanes - 1 - lane) * w;
  endfunction

  // Largest value representable in a signed qw-bit word.
  function automatic longint sat_max(input int unsigned qw);
    return (longint'(1) <<< (qw - 1)) - 1;
  endfunction

  // Smallest value representable in a signed qw-bit word.
  function automatic longint sat_min(input int unsigned qw);
    return -(longint'(1) <<< (qw - 1));
  endfunction

endpackage

// File: rtl/out_requant_pipe_requant_lane.sv
// Per-lane requantisation datapath (purely combinational).
// Stage-1 half: acc_i/shift_i/round_i -> r_c (rounded arithmetic shift, ACC_W+1 bits).
// Stage-2 half: r_i/relu_i -> q_c (saturated, optionally relu'd) and sat_c (clamp flag).
module requant_lane
  import out_requant_pipe_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned Q_W   = Q_W_DEF,
  parameter int unsigned SHW   = SHW_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [SHW-1:0]   shift_i,
  input  logic                    round_i,
  output logic signed [ACC_W:0]   r_c,
  input  logic signed [ACC_W:0]   r_i,
  input  logic                    relu_i,
  output logic        [Q_W-1:0]   q_c,
  output logic                    sat_c
);

  localparam int unsigned RW = ACC_W + 1;
  localparam logic signed [RW-1:0] QMAX = RW'(sat_max(Q_W));
  localparam logic signed [RW-1:0] QMIN = RW'(sat_min(Q_W));

  logic        [SHW-1:0] sh_c;
  logic signed [RW-1:0]  ext_c;
  logic signed [RW-1:0]  bias_c;
  logic signed [RW-1:0]  sum_c;

  // Round-half-up bias then arithmetic shift; the extra bit absorbs the bias carry.
  always_comb begin
    sh_c   = (32'(shift_i) >= ACC_W) ? SHW'(ACC_W - 1) : shift_i;
    ext_c  = {acc_i[ACC_W-1], acc_i};
    bias_c = '0;
    if (round_i && (sh_c != '0)) begin
      bias_c = RW'(1) << (sh_c - SHW'(1));
    end
    sum_c = ext_c + bias_c;
    r_c   = sum_c >>> sh_c;
  end

  // Saturate first so a clamped negative still counts as saturated after relu zeroing.
  always_comb begin
    sat_c = 1'b0;
    q_c   = r_i[Q_W-1:0];
    if (r_i > QMAX) begin
      q_c   = QMAX[Q_W-1:0];
      sat_c = 1'b1;
    end else if (r_i < QMIN) begin
      q_c   = QMIN[Q_W-1:0];
      sat_c = 1'b1;
    end
    if (relu_i && q_c[Q_W-1]) begin
      q_c = '0;
    end
  end

endmodule

// File: rtl/out_requant_pipe.sv
// Two-stage output requantisation pipeline with valid/ready handshake.
// Ports: clk, rstn (async active-low); in_valid/in_ready/in_acc with per-beat
// cfg_shift/cfg_round/cfg_relu; out_valid/out_ready/out_data; clr_sat and sat_cnt
// (running count of saturated lanes emitted, sticky at all-ones).
module out_requant_pipe
  import out_requant_pipe_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned Q_W   = Q_W_DEF,
  parameter int unsigned SHW   = SHW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_acc,
  input  logic [SHW-1:0]         cfg_shift,
  input  logic                   cfg_round,
  input  logic                   cfg_relu,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*Q_W-1:0]   out_data,
  input  logic                   clr_sat,
  output logic [CNT_W-1:0]       sat_cnt
);

  localparam int unsigned RW     = ACC_W + 1;
  localparam int unsigned NSAT_W = $clog2(LANES + 1);

  logic                  s1_adv_c;
  logic                  s2_adv_c;
  logic                  out_hs_c;
  logic signed [RW-1:0]  r_c [LANES];
  logic [LANES*Q_W-1:0]  q_pack_c;
  logic [LANES-1:0]      sat_c;
  logic [NSAT_W-1:0]     nsat_c;
  logic [CNT_W:0]        sat_sum_c;

  logic                  s1_valid_q, s1_valid_d;
  logic signed [RW-1:0]  s1_r_q [LANES];
  logic                  s1_relu_q;
  logic                  s2_valid_q, s2_valid_d;
  logic [LANES*Q_W-1:0]  out_data_q, out_data_d;
  logic [NSAT_W-1:0]     s2_nsat_q, s2_nsat_d;
  logic [CNT_W-1:0]      sat_cnt_q, sat_cnt_d;

  assign s2_adv_c = !s2_valid_q || out_ready;
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign out_hs_c = s2_valid_q && out_ready;
  assign nsat_c   = NSAT_W'($countones(sat_c));

  assign in_ready  = s1_adv_c;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign sat_cnt   = sat_cnt_q;

  // Lane datapaths plus their stage-1 data registers.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane #(
      .ACC_W (ACC_W),
      .Q_W   (Q_W),
      .SHW   (SHW)
    ) u_lane (
      .acc_i   (in_acc[lane_lsb(LANES, ACC_W, g) +: ACC_W]),
      .shift_i (cfg_shift),
      .round_i (cfg_round),
      .r_c     (r_c[g]),
      .r_i     (s1_r_q[g]),
      .relu_i  (s1_relu_q),
      .q_c     (q_pack_c[lane_lsb(LANES, Q_W, g) +: Q_W]),
      .sat_c   (sat_c[g])
    );

    always_ff @(posedge clk) begin
      if (s1_adv_c && in_valid) begin
        s1_r_q[g] <= r_c[g];
      end
    end
  end

  // Relu travels with the beat; shift/round are already applied in stage 1.
  always_ff @(posedge clk) begin
    if (s1_adv_c && in_valid) begin
      s1_relu_q <= cfg_relu;
    end
  end

  // Next-state for pipeline control, output register and saturation counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    s2_nsat_d  = s2_nsat_q;
    sat_cnt_d  = sat_cnt_q;
    sat_sum_c  = (CNT_W+1)'(sat_cnt_q) + (CNT_W+1)'(s2_nsat_q);

    if (s1_adv_c) begin
      s1_valid_d = in_valid;
    end
    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = q_pack_c;
        s2_nsat_d  = nsat_c;
      end
    end

    if (clr_sat) begin
      sat_cnt_d = '0;
    end else if (out_hs_c) begin
      sat_cnt_d = sat_sum_c[CNT_W] ? '1 : sat_sum_c[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      s2_nsat_q  <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      s2_nsat_q  <= s2_nsat_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

endmodule

// File: tb/tb_out_requant_pipe.sv
// Self-checking bench for out_requant_pipe: directed vectors, stall/reset scenarios
// and randomized traffic against an arithmetic reference model with a scoreboard.
module tb_out_requant_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned Q_W   = 8;
  localparam int unsigned SHW   = 5;
  localparam int unsigned CNT_W = 16;

  logic                   clk;
  logic                   rstn;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*ACC_W-1:0] in_acc;
  logic [SHW-1:0]         cfg_shift;
  logic                   cfg_round;
  logic                   cfg_relu;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*Q_W-1:0]   out_data;
  logic                   clr_sat;
  logic [CNT_W-1:0]       sat_cnt;

  out_requant_pipe #(
    .LANES (LANES), .ACC_W (ACC_W), .Q_W (Q_W), .SHW (SHW), .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .cfg_shift (cfg_shift),
    .cfg_round (cfg_round),
    .cfg_relu  (cfg_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .clr_sat   (clr_sat),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          nsat;
    int          cyc;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] out_log[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          exp_sat = 0;
  bit          chk_lat = 1'b1;
  bit          hold_v = 1'b0;
  logic [31:0] hold_d = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Reference: round-half-up/floor divide by 2^sh, clamp to int8, then relu.
  function automatic void lane_model(input longint acc, input int sh, input bit rnd,
                                     input bit relu, output logic [7:0] q, output bit sat);
    longint a;
    a = acc;
    if (sh >= 32) sh = 31;
    if (rnd && sh > 0) a = a + (longint'(1) <<< (sh - 1));
    a = a >>> sh;
    sat = 1'b0;
    if (a > 127) begin a = 127; sat = 1'b1; end
    else if (a < -128) begin a = -128; sat = 1'b1; end
    if (relu && a < 0) a = 0;
    q = a[7:0];
  endfunction

  function automatic exp_t model_beat();
    exp_t        e;
    logic [31:0] w;
    logic [7:0]  q;
    bit          s;
    e.data = '0;
    e.nsat = 0;
    e.cyc  = 0;
    for (int l = 0; l < 4; l++) begin
      w = in_acc[(3 - l) * 32 +: 32];
      lane_model(longint'(signed'(w)), int'(cfg_shift), cfg_round, cfg_relu, q, s);
      e.data[(3 - l) * 8 +: 8] = q;
      if (s) e.nsat++;
    end
    return e;
  endfunction

  task automatic set_beat(input logic signed [31:0] a0, input logic signed [31:0] a1,
                          input logic signed [31:0] a2, input logic signed [31:0] a3,
                          input int sh, input bit rnd, input bit relu);
    in_acc    = {a0, a1, a2, a3};
    cfg_shift = SHW'(sh);
    cfg_round = rnd;
    cfg_relu  = relu;
  endtask

  function automatic logic [31:0] rand_acc();
    case ($urandom_range(0, 2))
      0:       return 32'($urandom_range(0, 600)) - 32'd300;
      1:       return 32'($urandom_range(0, 40000)) - 32'd20000;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic rand_beat();
    set_beat(rand_acc(), rand_acc(), rand_acc(), rand_acc(), int'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // One clock: sample at negedge+1, score handshakes, advance to the next negedge.
  task automatic step(output bit ihs, output bit ohs);
    exp_t e;
    int   ns;
    #1;
    check("sat_cnt", 32'(sat_cnt), 32'(exp_sat));
    if (hold_v) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, hold_d);
    end
    ihs = in_valid && in_ready;
    ohs = out_valid && out_ready;
    ns  = 0;
    if (ohs) begin
      check("beat_pending", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e  = expq.pop_front();
        ns = e.nsat;
        check("out_data", out_data, e.data);
        if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
      end
      out_log.push_back(out_data);
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    if (ihs) begin
      e     = model_beat();
      e.cyc = cyc;
      expq.push_back(e);
    end
    @(posedge clk);
    if (clr_sat) exp_sat = 0;
    else if (ohs) exp_sat = (exp_sat + ns > 65535) ? 65535 : exp_sat + ns;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    bit ih, oh;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && expq.size() != 0; i++) step(ih, oh);
    check("drain_empty", 32'(expq.size()), 32'd0);
    step(ih, oh);
  endtask

  task automatic send_one();
    bit ih, oh;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      step(ih, oh);
      done = ih;
    end
    check("send_accepted", 32'(done), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    bit ih, oh;
    int sent, base, stall_left;
    bit newb;

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sat = 1'b0;
    set_beat(0, 0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_sat_cnt", 32'(sat_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Reference vector: round, then truncate, then relu.
    out_ready = 1'b1;
    set_beat(48, -48, 4096, -5000, 5, 1'b1, 1'b0);
    send_one(); drain();
    check("vec_round", out_log[out_log.size() - 1], 32'h02FF7F80);
    check("vec_round_sat", 32'(sat_cnt), 32'd2);
    set_beat(48, -48, 4096, -5000, 5, 1'b0, 1'b0);
    send_one(); drain();
    check("vec_trunc", out_log[out_log.size() - 1], 32'h01FE7F80);
    set_beat(48, -48, 4096, -5000, 5, 1'b1, 1'b1);
    send_one(); drain();
    check("vec_relu", out_log[out_log.size() - 1], 32'h02007F00);
    check("vec_relu_sat", 32'(sat_cnt), 32'd6);

    // Back-to-back config change: each beat keeps its own shift.
    in_valid = 1'b1;
    set_beat(48, -48, 100, -100, 5, 1'b1, 1'b0);
    step(ih, oh);
    check("b2b_first_accept", 32'(ih), 32'd1);
    set_beat(48, -48, 100, -100, 0, 1'b1, 1'b0);
    step(ih, oh);
    check("b2b_second_accept", 32'(ih), 32'd1);
    drain();
    check("b2b_shift5", out_log[out_log.size() - 2], 32'h02FF03FD);
    check("b2b_shift0", out_log[out_log.size() - 1], 32'h30D0649C);

    // Randomized traffic with random backpressure and occasional counter clears.
    chk_lat = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_sat   = ($urandom_range(0, 63) == 0);
      step(ih, oh);
    end
    clr_sat = 1'b0;
    drain();

    // Eight-beat stream with a three-cycle output stall after the second beat.
    sent = 0; base = out_log.size(); stall_left = 3; newb = 1'b1;
    for (int i = 0; i < 60 && (sent < 8 || expq.size() != 0); i++) begin
      if (newb) begin rand_beat(); newb = 1'b0; end
      in_valid  = (sent < 8);
      out_ready = 1'b1;
      if (out_log.size() - base >= 2 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        if (stall_left == 0) begin
          #1;
          check("in_ready_stalled", 32'(in_ready), 32'd0);
        end
      end
      step(ih, oh);
      if (ih) begin sent++; newb = 1'b1; end
    end
    check("stream_count", 32'(out_log.size() - base), 32'd8);
    drain();
    chk_lat = 1'b1;

    // Reset with both stages full: nothing stale may appear afterwards.
    chk_lat = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    repeat (4) begin rand_beat(); step(ih, oh); end
    #1;
    check("pre_reset_full", 32'(out_valid && !in_ready), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("mid_reset_out_valid", 32'(out_valid), 32'd0);
    check("mid_reset_out_data", out_data, 32'd0);
    check("mid_reset_sat_cnt", 32'(sat_cnt), 32'd0);
    expq.delete(); exp_sat = 0; hold_v = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("in_ready_after_mid_reset", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b1; chk_lat = 1'b1;
    repeat (4) step(ih, oh);
    check("no_stale_beat", 32'(out_valid), 32'd0);
    rand_beat();
    send_one(); drain();

    // Drive the saturation counter to its sticky limit.
    clr_sat = 1'b1; step(ih, oh); clr_sat = 1'b0;
    set_beat(1000, -1000, 1000, -1000, 0, 1'b0, 1'b0);
    sent = 0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17000 && sent < 16383; i++) begin
      step(ih, oh);
      if (ih) sent++;
    end
    in_valid = 1'b0;
    drain();
    set_beat(1000, -1000, 0, 0, 0, 1'b0, 1'b0);
    send_one(); drain();
    check("sat_fffe", 32'(sat_cnt), 32'h0000FFFE);
    set_beat(1000, -1000, 1000, -1000, 0, 1'b0, 1'b0);
    send_one(); drain();
    check("sat_ffff", 32'(sat_cnt), 32'h0000FFFF);
    send_one(); drain();
    check("sat_sticky", 32'(sat_cnt), 32'h0000FFFF);

    // Clear in the same cycle as a saturated beat's output handshake.
    send_one();
    step(ih, oh);
    clr_sat = 1'b1;
    step(ih, oh);
    check("clr_with_handshake", 32'(oh), 32'd1);
    clr_sat = 1'b0;
    step(ih, oh);
    check("clr_priority", 32'(sat_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
